mor1kx_rf_multiport: RTL and testbench

MOR1KX_RF_MULTIPORT -- requirements
Module: mor1kx_rf_multiport

---
 rtl/mor1kx_rf_pkg.sv | 24 ++
 rtl/mor1kx_simple_dpram_sclk.sv | 49 ++++
 rtl/mor1kx_rf_multiport.sv | 135 +++++++++++++
 tb/tb_mor1kx_rf_multiport.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_rf_pkg.sv
// Shared constants and types for the multiport GPR file.
// Optional feature macro: MOR1KX_RF_R0_ZERO_EN (r0 hard-wired to zero).
package mor1kx_rf_pkg;

    // Legal range of independent read ports
    localparam int MIN_READ_PORTS = 1;
    localparam int MAX_READ_PORTS = 4;

    // Default slice widths of the packed per-port buses
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    // Per-port hold state for forcing RAM refresh after a bypass
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_e;

    // Lowest bit index of port p in a bus of w-bit slices
    function automatic int port_lsb(input int p, input int w);
        return p * w;
    endfunction

endpackage

// File: rtl/mor1kx_simple_dpram_sclk.sv
// Single-clock dual-port RAM, one write and one registered read port.
// Optional internal write-to-read bypass selected by ENABLE_BYPASS.
module mor1kx_simple_dpram_sclk #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ENABLE_BYPASS = 1
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array write port
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= din;
    end

    // Registered read; returns pre-write content on a collision
    always_ff @(posedge clk) begin
        if (re)
            rdata_q <= mem[raddr];
    end

    if (ENABLE_BYPASS != 0) begin : g_bypass
        logic                  hit_q;
        logic [DATA_WIDTH-1:0] din_q;

        // Remember a same-edge collision so new data wins
        always_ff @(posedge clk) begin
            if (re) begin
                hit_q <= we && (waddr == raddr);
                din_q <= din;
            end
        end

        assign dout = hit_q ? din_q : rdata_q;
    end else begin : g_no_bypass
        assign dout = rdata_q;
    end

endmodule

// File: rtl/mor1kx_rf_multiport.sv
// Multi-read-port GPR file: one RAM copy per read port, shared write.
// Macro MOR1KX_RF_R0_ZERO_EN makes r0 read as zero and drops its writes.
module mor1kx_rf_multiport
    import mor1kx_rf_pkg::*;
#(
    parameter int OPTION_RF_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int OPTION_RF_WORDS      = 32,
    parameter int OPTION_OPERAND_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_READ_PORTS       = 2
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]                wr_adr_i,
    input  logic                                           wr_we_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]                wr_dat_i,
    input  logic [NUM_READ_PORTS*OPTION_RF_ADDR_WIDTH-1:0] rd_adr_i,
    input  logic [NUM_READ_PORTS-1:0]                      rd_re_i,
    output logic [NUM_READ_PORTS*OPTION_OPERAND_WIDTH-1:0] rd_dat_o
);

    localparam int AW = OPTION_RF_ADDR_WIDTH;
    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int NP = NUM_READ_PORTS;

    if (NP < MIN_READ_PORTS || NP > MAX_READ_PORTS) begin : g_bad_np
        $error("NUM_READ_PORTS out of range");
    end

    // Address is a real register that can hold data
    function automatic logic adr_ok(input logic [AW-1:0] a);
        logic ok;
        ok = ({{(32-AW){1'b0}}, a} < 32'(OPTION_RF_WORDS));
`ifdef MOR1KX_RF_R0_ZERO_EN
        if (a == '0)
            ok = 1'b0;
`endif
        return ok;
    endfunction

    logic          wr_ok;
    logic [AW-1:0] wr_adr_q;
    logic [W-1:0]  wr_dat_q;
    logic          wr_vld_q;

    assign wr_ok = wr_we_i && rst_n && adr_ok(wr_adr_i);

    // Track the write of the previous edge for the bypass path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_adr_q <= '0;
            wr_dat_q <= '0;
            wr_vld_q <= 1'b0;
        end else begin
            wr_vld_q <= wr_ok;
            if (wr_ok) begin
                wr_adr_q <= wr_adr_i;
                wr_dat_q <= wr_dat_i;
            end
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_port
        logic [AW-1:0] rd_adr;
        logic [AW-1:0] lat_adr;
        logic          lat_ok;
        logic          vld;
        logic          re;
        logic          bypass;
        logic          ram_re;
        logic [AW-1:0] ram_adr;
        logic [W-1:0]  ram_dat;
        hold_state_e   using_last;
        hold_state_e   using_last_nxt;

        assign rd_adr = rd_adr_i[port_lsb(p, AW) +: AW];
        assign re     = rd_re_i[p] && rst_n;
        assign bypass = wr_vld_q && (wr_adr_q == lat_adr);

        // Latch the read address and its validity on each read
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lat_adr    <= '0;
                lat_ok     <= 1'b0;
                vld        <= 1'b0;
                using_last <= IDLE;
            end else begin
                using_last <= using_last_nxt;
                if (re) begin
                    lat_adr <= rd_adr;
                    lat_ok  <= adr_ok(rd_adr);
                    vld     <= 1'b1;
                end
            end
        end

        // Hold FSM and RAM read request; refresh after any bypass
        always_comb begin
            using_last_nxt = using_last;
            ram_re         = re || bypass;
            ram_adr        = re ? rd_adr : lat_adr;
            unique case (using_last)
                IDLE: begin
                    if (!re && bypass)
                        using_last_nxt = HOLD;
                end
                HOLD: begin
                    if (re)
                        using_last_nxt = IDLE;
                    else
                        ram_re = 1'b1;
                end
            endcase
        end

        mor1kx_simple_dpram_sclk #(
            .ADDR_WIDTH    (AW),
            .DATA_WIDTH    (W),
            .ENABLE_BYPASS (0)
        ) u_ram (
            .clk   (clk),
            .raddr (ram_adr),
            .re    (ram_re),
            .waddr (wr_adr_i),
            .we    (wr_ok),
            .din   (wr_dat_i),
            .dout  (ram_dat)
        );

        assign rd_dat_o[port_lsb(p, W) +: W] =
            !(vld && lat_ok) ? '0 :
            bypass           ? wr_dat_q :
                               ram_dat;
    end

endmodule

// File: tb/tb_mor1kx_rf_multiport.sv
// Directed vector bench for the multiport GPR file.
// Honours MOR1KX_RF_R0_ZERO_EN for the r0 expectation.
module tb_mor1kx_rf_multiport;

    localparam int AW = 5;
    localparam int W  = 32;
    localparam int NP = 4;
    localparam int NW = 24;

`ifdef MOR1KX_RF_R0_ZERO_EN
    localparam logic [W-1:0] R0_EXP = 32'h0;
`else
    localparam logic [W-1:0] R0_EXP = 32'hFFFF_FFFF;
`endif

    typedef struct {
        logic                  rst;
        logic                  we;
        logic [AW-1:0]         wa;
        logic [W-1:0]          wd;
        logic [NP-1:0]         re;
        logic [NP-1:0][AW-1:0] ra;
        logic [NP-1:0][W-1:0]  exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [AW-1:0]       wr_adr_i;
    logic                wr_we_i;
    logic [W-1:0]        wr_dat_i;
    logic [NP*AW-1:0]    rd_adr_i;
    logic [NP-1:0]       rd_re_i;
    logic [NP*W-1:0]     rd_dat_o;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t vecs [21];

    always #5 clk = ~clk;

    mor1kx_rf_multiport #(
        .OPTION_RF_ADDR_WIDTH (AW),
        .OPTION_RF_WORDS      (NW),
        .OPTION_OPERAND_WIDTH (W),
        .NUM_READ_PORTS       (NP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_adr_i (wr_adr_i),
        .wr_we_i  (wr_we_i),
        .wr_dat_i (wr_dat_i),
        .rd_adr_i (rd_adr_i),
        .rd_re_i  (rd_re_i),
        .rd_dat_o (rd_dat_o)
    );

    function automatic vec_t mk(
        input logic rst, input logic we,
        input int wa, input logic [W-1:0] wd,
        input logic [3:0] re,
        input int a0, input int a1, input int a2, input int a3,
        input logic [W-1:0] e0, input logic [W-1:0] e1,
        input logic [W-1:0] e2, input logic [W-1:0] e3);
        vec_t v;
        v.rst = rst;
        v.we  = we;
        v.wa  = AW'(wa);
        v.wd  = wd;
        v.re  = re;
        v.ra[0] = AW'(a0);
        v.ra[1] = AW'(a1);
        v.ra[2] = AW'(a2);
        v.ra[3] = AW'(a3);
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        return v;
    endfunction

    initial begin
        logic [W-1:0] D, A, B;
        D = 32'hDEAD_BEEF;
        A = 32'h1111_1111;
        B = 32'hA5A5_A5A5;
        // reset, idle, write r3
        vecs[0]  = mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 3, A, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        // read r3 on p0; write-first collision on p1
        vecs[3]  = mk(0, 0, 0, 0, 4'h1, 3, 0, 0, 0, A, 0, 0, 0);
        vecs[4]  = mk(0, 1, 5, B, 4'h2, 0, 5, 0, 0, A, B, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, A, B, 0, 0);
        // live tracking of r7 on p0
        vecs[6]  = mk(0, 1, 7, 0, 4'h1, 7, 0, 0, 0, 0, B, 0, 0);
        vecs[7]  = mk(0, 1, 7, 1, 4'h0, 0, 0, 0, 0, 1, B, 0, 0);
        vecs[8]  = mk(0, 1, 8, 2, 4'h0, 0, 0, 0, 0, 1, B, 0, 0);
        vecs[9]  = mk(0, 1, 7, 3, 4'h0, 0, 0, 0, 0, 3, B, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 3, B, 0, 0);
        // all ports on r9 during its write
        vecs[11] = mk(0, 1, 9, D, 4'hF, 9, 9, 9, 9, D, D, D, D);
        vecs[12] = mk(0, 0, 0, 0, 4'h2, 0, 3, 0, 0, D, A, D, D);
        // r0 behaviour
        vecs[13] = mk(0, 1, 0, 32'hFFFF_FFFF, 4'h0,
                      0, 0, 0, 0, D, A, D, D);
        vecs[14] = mk(0, 0, 0, 0, 4'h4, 0, 0, 0, 0, D, A, R0_EXP, D);
        // out-of-range write ignored, read returns 0
        vecs[15] = mk(0, 1, 25, 32'h1234_5678, 4'h8,
                      0, 0, 0, 25, D, A, R0_EXP, 0);
        // reset during a write, then first-edge write
        vecs[16] = mk(1, 1, 2, 32'hCAFE_F00D, 4'h0,
                      0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17] = mk(0, 1, 2, 32'h2222_2222, 4'h0,
                      0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 4'h1, 2, 0, 0, 0,
                      32'h2222_2222, 0, 0, 0);
        vecs[19] = mk(0, 1, 2, 32'h3333_3333, 4'h0, 0, 0, 0, 0,
                      32'h3333_3333, 0, 0, 0);
        vecs[20] = mk(0, 1, 3, 32'h4444_4444, 4'h0, 0, 0, 0, 0,
                      32'h3333_3333, 0, 0, 0);

        rst_n    = 1'b0;
        wr_adr_i = '0;
        wr_we_i  = 1'b0;
        wr_dat_i = '0;
        rd_adr_i = '0;
        rd_re_i  = '0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            rst_n    = ~vecs[i].rst;
            wr_we_i  = vecs[i].we;
            wr_adr_i = vecs[i].wa;
            wr_dat_i = vecs[i].wd;
            rd_re_i  = vecs[i].re;
            rd_adr_i = vecs[i].ra;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                n_chk++;
                if (rd_dat_o[p*W +: W] !== vecs[i].exp[p]) begin
                    n_fail++;
                    $display("FAIL vec%0d port%0d: got %h want %h",
                             i, p, rd_dat_o[p*W +: W],
                             vecs[i].exp[p]);
                end
            end
        end

        // hand sequence: bypass then fallback after same-edge read
        @(negedge clk);
        wr_we_i  = 1'b1;
        wr_adr_i = 5'd6;
        wr_dat_i = 32'h6666_0001;
        rd_re_i  = 4'h2;
        rd_adr_i = {5'd0, 5'd0, 5'd6, 5'd0};
        @(negedge clk);
        wr_adr_i = 5'd4;
        wr_dat_i = 32'h4444_0004;
        rd_re_i  = 4'h0;
        n_chk++;
        if (rd_dat_o[1*W +: W] !== 32'h6666_0001) begin
            n_fail++;
            $display("FAIL seq_bypass: got %h want %h",
                     rd_dat_o[1*W +: W], 32'h6666_0001);
        end
        @(negedge clk);
        wr_we_i = 1'b0;
        n_chk++;
        if (rd_dat_o[1*W +: W] !== 32'h6666_0001) begin
            n_fail++;
            $display("FAIL seq_fallback: got %h want %h",
                     rd_dat_o[1*W +: W], 32'h6666_0001);
        end
        n_chk++;
        if (rd_dat_o[0*W +: W] !== 32'h3333_3333) begin
            n_fail++;
            $display("FAIL seq_p0_keep: got %h want %h",
                     rd_dat_o[0*W +: W], 32'h3333_3333);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
